// File: rtl/cond_pkg.sv
// Shared condition-code encodings and NZCV bit positions for the conditional-execution stage.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM condition field against stored NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // The reserved 1111 encoding is treated as "never".
    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ~(n ^ v);
            COND_LT: cond_ex = n ^ v;
            COND_GT: cond_ex = ~z & ~(n ^ v);
            COND_LE: cond_ex = z | (n ^ v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Flag register, condition gating of decoder write enables, and registered ALU result for write-back.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             Stall,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [WIDTH-1:0] ResultReg,
    output logic             ResultValid
);

    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       nz_en;
    logic       cv_en;

    assign Flags = {nz_q, cv_q};

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (Flags),
        .cond_ex (CondEx)
    );

    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & CondEx & ~NoWrite;
    assign MemWrite = MemW & CondEx;

    assign nz_en = ~Stall & CondEx & FlagW[1];
    assign cv_en = ~Stall & CondEx & FlagW[0];

    // N,Z and C,V halves update independently so logic ops can preserve carry/overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            if (nz_en) nz_q <= ALUFlags[FLAG_N:FLAG_Z];
            if (cv_en) cv_q <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ResultReg   <= WIDTH'(0);
            ResultValid <= 1'b0;
        end else if (~Stall) begin
            if (RegWrite) ResultReg <= ALUResult;
            ResultValid <= RegWrite;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed self-checking bench for cond_flag_unit at WIDTH=4.
module tb_cond_flag_unit;
    import cond_pkg::*;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [WIDTH-1:0] ALUResult;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic             Stall;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondEx;
    logic [3:0]       Flags;
    logic [WIDTH-1:0] ResultReg;
    logic             ResultValid;

    int nassert = 0;
    int nfail   = 0;

    cond_flag_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .Cond        (Cond),
        .ALUFlags    (ALUFlags),
        .ALUResult   (ALUResult),
        .FlagW       (FlagW),
        .PCS         (PCS),
        .RegW        (RegW),
        .MemW        (MemW),
        .NoWrite     (NoWrite),
        .Stall       (Stall),
        .PCSrc       (PCSrc),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .CondEx      (CondEx),
        .Flags       (Flags),
        .ResultReg   (ResultReg),
        .ResultValid (ResultValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Cond = COND_AL; ALUFlags = 4'b0000; ALUResult = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Stall = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst_flags", Flags, 4'b0000);
        check("rst_result", ResultReg, 4'b0000);
        check("rst_valid", 4'(ResultValid), 4'b0000);
        reset = 1'b0;

        // After reset: EQ fails, NE and AL pass
        Cond = COND_EQ; RegW = 1'b1; #1;
        check("eq_after_rst_condex", 4'(CondEx), 4'b0000);
        check("eq_after_rst_regwrite", 4'(RegWrite), 4'b0000);
        check("eq_after_rst_flags", Flags, 4'b0000);
        Cond = COND_NE; #1;
        check("ne_after_rst", 4'(CondEx), 4'b0001);
        Cond = COND_AL; RegW = 1'b0; #1;
        check("al_after_rst", 4'(CondEx), 4'b0001);
        Cond = COND_NV; #1;
        check("nv_never", 4'(CondEx), 4'b0000);

        // SUB 4-2: flags 0010, result 0010
        tick();
        Cond = COND_AL; ALUFlags = 4'b0010; ALUResult = 4'b0010; FlagW = 2'b11; RegW = 1'b1; #1;
        check("sub_regwrite", 4'(RegWrite), 4'b0001);
        check("sub_flags_not_yet", Flags, 4'b0000);
        tick();
        check("sub_flags", Flags, 4'b0010);
        check("sub_result", ResultReg, 4'b0010);
        check("sub_valid", 4'(ResultValid), 4'b0001);
        FlagW = 2'b00; RegW = 1'b0;
        Cond = COND_CS; #1;
        check("cs_pass", 4'(CondEx), 4'b0001);
        Cond = COND_HI; #1;
        check("hi_pass", 4'(CondEx), 4'b0001);
        Cond = COND_CC; #1;
        check("cc_fail", 4'(CondEx), 4'b0000);
        Cond = COND_LS; #1;
        check("ls_fail", 4'(CondEx), 4'b0000);

        // CMP equal values: flags only
        tick();
        Cond = COND_AL; ALUFlags = 4'b0110; ALUResult = 4'b1111; FlagW = 2'b11;
        RegW = 1'b1; NoWrite = 1'b1; #1;
        check("cmp_regwrite", 4'(RegWrite), 4'b0000);
        tick();
        check("cmp_flags", Flags, 4'b0110);
        check("cmp_result_held", ResultReg, 4'b0010);
        check("cmp_valid_clear", 4'(ResultValid), 4'b0000);
        FlagW = 2'b00; RegW = 1'b0; NoWrite = 1'b0;
        Cond = COND_EQ; #1;
        check("eq_pass", 4'(CondEx), 4'b0001);
        Cond = COND_NE; #1;
        check("ne_fail", 4'(CondEx), 4'b0000);
        Cond = COND_LE; #1;
        check("le_pass_z", 4'(CondEx), 4'b0001);

        // Restore Flags=0010, then partial updates
        tick();
        Cond = COND_AL; ALUFlags = 4'b0010; FlagW = 2'b11;
        tick();
        check("restore_flags", Flags, 4'b0010);
        ALUFlags = 4'b1001; FlagW = 2'b10;
        tick();
        check("nz_only", Flags, 4'b1010);
        FlagW = 2'b00;
        Cond = COND_LT; #1;
        check("lt_pass", 4'(CondEx), 4'b0001);
        Cond = COND_GE; #1;
        check("ge_fail", 4'(CondEx), 4'b0000);
        Cond = COND_MI; #1;
        check("mi_pass", 4'(CondEx), 4'b0001);
        tick();
        Cond = COND_AL; ALUFlags = 4'b0101; FlagW = 2'b01;
        tick();
        check("cv_only", Flags, 4'b1001);
        Cond = COND_VS; FlagW = 2'b00; #1;
        check("vs_pass", 4'(CondEx), 4'b0001);
        Cond = COND_GT; #1;
        check("gt_pass", 4'(CondEx), 4'b0001);

        // Load a valid result, then a failed condition
        tick();
        Cond = COND_AL; ALUResult = 4'b0111; RegW = 1'b1; PCS = 1'b1; MemW = 1'b1; #1;
        check("al_pcsrc", 4'(PCSrc), 4'b0001);
        check("al_memwrite", 4'(MemWrite), 4'b0001);
        tick();
        check("load_result", ResultReg, 4'b0111);
        check("load_valid", 4'(ResultValid), 4'b0001);
        Cond = COND_EQ; FlagW = 2'b11; ALUFlags = 4'b0100; ALUResult = 4'b0001; #1;
        check("fail_condex", 4'(CondEx), 4'b0000);
        check("fail_pcsrc", 4'(PCSrc), 4'b0000);
        check("fail_memwrite", 4'(MemWrite), 4'b0000);
        check("fail_regwrite", 4'(RegWrite), 4'b0000);
        tick();
        check("fail_flags", Flags, 4'b1001);
        check("fail_result", ResultReg, 4'b0111);
        check("fail_valid", 4'(ResultValid), 4'b0000);

        // Stall a passing op for two cycles
        Cond = COND_AL; ALUFlags = 4'b0110; ALUResult = 4'b0011; Stall = 1'b1; #1;
        check("stall_regwrite_comb", 4'(RegWrite), 4'b0001);
        check("stall_pcsrc_comb", 4'(PCSrc), 4'b0001);
        tick();
        check("stall1_flags", Flags, 4'b1001);
        check("stall1_result", ResultReg, 4'b0111);
        check("stall1_valid", 4'(ResultValid), 4'b0000);
        tick();
        check("stall2_flags", Flags, 4'b1001);
        check("stall2_result", ResultReg, 4'b0111);
        check("stall2_valid", 4'(ResultValid), 4'b0000);

        // Unstall one edge so state is nonzero, then async reset during a stall
        Stall = 1'b0;
        tick();
        check("unstall_flags", Flags, 4'b0110);
        check("unstall_result", ResultReg, 4'b0011);
        check("unstall_valid", 4'(ResultValid), 4'b0001);
        Stall = 1'b1; #2;
        reset = 1'b1; #1;
        check("async_rst_flags", Flags, 4'b0000);
        check("async_rst_result", ResultReg, 4'b0000);
        check("async_rst_valid", 4'(ResultValid), 4'b0000);
        tick();
        reset = 1'b0; Stall = 1'b0; PCS = 1'b0; MemW = 1'b0; RegW = 1'b0; FlagW = 2'b00;
        Cond = COND_EQ; #1;
        check("post_rst_eq", 4'(CondEx), 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
